ram_scanner: RTL and testbench

Parametrised scanning RAM controller: an inferred simple-dual-port memory with one edge-triggered write port and a read port whose address is advanced automatically by an internal prescaler, stepped manually, or held. It sits between board-level synchronisers (metastability_filter) and seg7 display logic in DE1_SoC-class top levels. It replaces fixed-size IP RAM plus free-running divider arrangements. All inputs arrive already synchronised to `clk`.

---
 rtl/ram_scanner_pkg.sv | 21 ++
 rtl/ram_scanner_if.sv | 30 +++
 rtl/ram_scanner_edge_detect.sv | 21 ++
 rtl/ram_scanner.sv | 101 ++++++++++
 tb/tb_ram_scanner.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_scanner_pkg.sv
// Shared types and helpers for the scanning RAM controller: scan mode encoding
// and depth/mode helper functions.
package ram_scanner_pkg;

  typedef enum logic [1:0] {
    MODE_AUTO   = 2'd0,
    MODE_MANUAL = 2'd1,
    MODE_HOLD   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  // The reserved encoding behaves exactly like HOLD.
  function automatic mode_e norm_mode(input mode_e m);
    return (m == MODE_RSVD) ? MODE_HOLD : m;
  endfunction

endpackage

// File: rtl/ram_scanner_if.sv
// Write/scan-control bus of ram_scanner; master drives the controls and
// write port, slave (the scanner) returns the read side and status pulses.
interface ram_scanner_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 5
);
  import ram_scanner_pkg::*;

  mode_e                  mode;
  logic                   step;
  logic                   wr_req;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   rd_valid;
  logic                   wr_done;
  logic                   scan_wrap;

  modport master (
    output mode, step, wr_req, wr_addr, wr_data,
    input  rd_addr, rd_data, rd_valid, wr_done, scan_wrap
  );

  modport slave (
    input  mode, step, wr_req, wr_addr, wr_data,
    output rd_addr, rd_data, rd_valid, wr_done, scan_wrap
  );

endinterface

// File: rtl/ram_scanner_edge_detect.sv
// Rising-edge detector; history resets high so a level already asserted
// during reset does not produce a pulse on release.
module edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic sig,
  output logic rise
);

  logic hist;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hist <= 1'b1;
    else          hist <= sig;
  end

  assign rise = sig & ~hist;

endmodule

// File: rtl/ram_scanner.sv
// Scanning simple-dual-port RAM controller: edge-triggered writes, read address
// stepped by prescaler (AUTO), step edges (MANUAL) or frozen (HOLD).
// Define RAM_SCANNER_BYPASS_EN to forward same-address write data to rd_data.
module ram_scanner
  import ram_scanner_pkg::*;
#(
  parameter int DATA_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 5,
  parameter int SCAN_PERIOD = 67_108_864
) (
  input  logic          clk,
  input  logic          reset_n,
  ram_scanner_if.slave  bus
);

  localparam int                  DEPTH      = depth_of(ADDR_WIDTH);
  localparam int                  PRESC_W    = $clog2(SCAN_PERIOD);
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(SCAN_PERIOD - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_rise, step_rise;
  mode_e                 mode_cur, mode_q;
  logic                  mode_changed;
  logic [PRESC_W-1:0]    presc_q, presc_base, presc_d;
  logic                  tick, advance;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_word;
  logic                  rd_valid_q, wr_done_q, scan_wrap_q;

  edge_detect u_wr_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .sig     (bus.wr_req),
    .rise    (wr_rise)
  );

  edge_detect u_step_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .sig     (bus.step),
    .rise    (step_rise)
  );

  assign mode_cur     = norm_mode(bus.mode);
  assign mode_changed = (mode_cur != mode_q);

  // A mode change counts as prescaler phase 0, so AUTO re-entry advances
  // exactly SCAN_PERIOD cycles later.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    presc_base = mode_changed ? '0 : presc_q;
    presc_d    = '0;
    tick       = 1'b0;
    if (mode_cur == MODE_AUTO) begin
      if (presc_base == PRESC_LAST) tick    = 1'b1;
      else                          presc_d = presc_base + PRESC_W'(1);
    end
  end

  assign advance = tick | ((mode_cur == MODE_MANUAL) & step_rise);

`ifdef RAM_SCANNER_BYPASS_EN
  assign rd_word = (wr_rise && (bus.wr_addr == rd_addr_q)) ? bus.wr_data : mem[rd_addr_q];
`else
  assign rd_word = mem[rd_addr_q];
`endif

  // NOTE: the array has no reset so it maps onto block RAM; only the
  // surrounding control and output registers are reset.
  always_ff @(posedge clk) begin
    if (wr_rise) mem[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= MODE_HOLD;
      presc_q     <= '0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      wr_done_q   <= 1'b0;
      scan_wrap_q <= 1'b0;
    end else begin
      mode_q      <= mode_cur;
      presc_q     <= presc_d;
      if (advance) rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
      rd_data_q   <= rd_word;
      rd_valid_q  <= ~advance;
      wr_done_q   <= wr_rise;
      scan_wrap_q <= advance && (rd_addr_q == '1);
    end
  end

  assign bus.rd_addr   = rd_addr_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.wr_done   = wr_done_q;
  assign bus.scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_ram_scanner.sv
// Self-checking bench for ram_scanner (DATA_WIDTH=4, ADDR_WIDTH=2, SCAN_PERIOD=8);
// inputs change and outputs are sampled on the falling clock edge.
module tb_ram_scanner;
  import ram_scanner_pkg::*;

  localparam int DW = 4;
  localparam int AW = 2;
  localparam int SP = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ram_scanner_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_scanner #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SCAN_PERIOD(SP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_vec_t;

  typedef struct {
    bit            do_step;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    bit            exp_wrap;
  } scan_vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } rd_exp_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] mem_model [4];
  rd_exp_t       sb_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    cyc();
    check("wr_done_pulse", bus.wr_done, 1);
    bus.wr_req   = 1'b0;
    mem_model[a] = d;
    cyc();
    check("wr_done_clear", bus.wr_done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wr_vec_t       wr_tab [3];
    scan_vec_t     scan_tab [5];
    rd_exp_t       e;
    int            done_cnt, wrap_cnt, low_cnt, w;
    logic [AW-1:0] exp_a;

    wr_tab   = '{'{2'd2, 4'hA}, '{2'd3, 4'h6}, '{2'd2, 4'hC}};
    scan_tab = '{'{1'b0, 2'd0, 4'hF, 1'b0},
                 '{1'b1, 2'd1, 4'h3, 1'b0},
                 '{1'b1, 2'd2, 4'hC, 1'b0},
                 '{1'b1, 2'd3, 4'h6, 1'b0},
                 '{1'b1, 2'd0, 4'hF, 1'b1}};

    // Reset, with wr_req held high through reset.
    reset_n     = 1'b0;
    bus.mode    = MODE_HOLD;
    bus.step    = 1'b0;
    bus.wr_req  = 1'b1;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    repeat (3) cyc();
    reset_n = 1'b1;
    #1;
    check("rst_rd_addr", bus.rd_addr, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_wr_done", bus.wr_done, 0);
    check("rst_scan_wrap", bus.scan_wrap, 0);
    cyc();
    check("held_through_reset_no_write", bus.wr_done, 0);
    check("hold_rd_valid", bus.rd_valid, 1);
    bus.wr_req = 1'b0;
    cyc();

    // Write/readback at the held address, old-data vs bypass behaviour.
    do_write(2'd0, 4'h2);
    check("pre_value", bus.rd_data, 4'h2);
    bus.wr_req  = 1'b1;
    bus.wr_addr = 2'd0;
    bus.wr_data = 4'hF;
    cyc();
    check("wr_done_t1", bus.wr_done, 1);
    check("rd_valid_t1", bus.rd_valid, 1);
`ifdef RAM_SCANNER_BYPASS_EN
    check("rdw_t1_bypass", bus.rd_data, 4'hF);
`else
    check("rdw_t1_old", bus.rd_data, 4'h2);
`endif
    bus.wr_req   = 1'b0;
    mem_model[0] = 4'hF;
    cyc();
    check("rdw_t2_new", bus.rd_data, 4'hF);
    check("rd_valid_t2", bus.rd_valid, 1);

    // Held wr_req: one write of the first data value.
    bus.wr_req  = 1'b1;
    bus.wr_addr = 2'd1;
    bus.wr_data = 4'h3;
    done_cnt    = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus.wr_done) done_cnt++;
      if (i == 0) bus.wr_data = 4'h5;
    end
    bus.wr_req = 1'b0;
    cyc();
    if (bus.wr_done) done_cnt++;
    check("held_wr_req_one_pulse", done_cnt, 1);
    mem_model[1] = 4'h3;

    foreach (wr_tab[i]) do_write(wr_tab[i].addr, wr_tab[i].data);

    // MANUAL scan: expectations queued when the step is driven.
    bus.mode = MODE_MANUAL;
    cyc();
    foreach (scan_tab[i]) begin
      sb_q.push_back('{scan_tab[i].exp_addr, scan_tab[i].exp_data});
      if (scan_tab[i].do_step) begin
        bus.step = 1'b1;
        cyc();
        check("step_scan_wrap", bus.scan_wrap, scan_tab[i].exp_wrap);
        check("step_rd_valid_drop", bus.rd_valid, 0);
        bus.step = 1'b0;
      end
      w = 0;
      while (!bus.rd_valid && w < 4) begin
        cyc();
        w++;
      end
      if (!bus.rd_valid) check("rd_valid_timeout", bus.rd_valid, 1);
      e = sb_q.pop_front();
      check("scan_rd_addr", bus.rd_addr, e.addr);
      check("scan_rd_data", bus.rd_data, e.data);
    end

    // step held high counts once.
    bus.step = 1'b1;
    repeat (5) cyc();
    bus.step = 1'b0;
    cyc();
    check("step_held_once", bus.rd_addr, 1);

    // HOLD freezes rd_addr, ignores step, and tracks writes.
    bus.mode = MODE_HOLD;
    cyc();
    bus.step = 1'b1;
    cyc();
    bus.step = 1'b0;
    repeat (10) cyc();
    check("hold_freeze", bus.rd_addr, 1);
    do_write(2'd1, 4'h7);
    check("hold_track_write", bus.rd_data, 4'h7);

    // AUTO from 1: advance every SP cycles, first one SP cycles after switch.
    bus.mode = MODE_AUTO;
    wrap_cnt = 0;
    low_cnt  = 0;
    for (int k = 1; k <= 4 * SP; k++) begin
      cyc();
      exp_a = AW'((1 + k / SP) % 4);
      check("auto_rd_addr", bus.rd_addr, exp_a);
      if (bus.scan_wrap) wrap_cnt++;
      if (!bus.rd_valid) low_cnt++;
      else check("auto_rd_data", bus.rd_data, mem_model[exp_a]);
    end
    check("auto_wrap_count", wrap_cnt, 1);
    check("auto_valid_drops", low_cnt, 4);

    bus.mode = MODE_RSVD;
    repeat (10) cyc();
    check("rsvd_as_hold", bus.rd_addr, 1);

    // Async reset between edges mid-scan; memory survives.
    bus.mode = MODE_AUTO;
    repeat (10) cyc();
    check("pre_reset_addr", bus.rd_addr, 2);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rd_addr", bus.rd_addr, 0);
    check("async_rd_data", bus.rd_data, 0);
    check("async_rd_valid", bus.rd_valid, 0);
    check("async_wr_done", bus.wr_done, 0);
    check("async_scan_wrap", bus.scan_wrap, 0);
    @(negedge clk);
    bus.mode = MODE_HOLD;
    reset_n  = 1'b1;
    #1;
    check("release_rd_valid", bus.rd_valid, 0);
    cyc();
    check("persist_addr0", bus.rd_data, mem_model[0]);
    check("persist_valid", bus.rd_valid, 1);
    bus.mode = MODE_MANUAL;
    bus.step = 1'b1;
    cyc();
    bus.step = 1'b0;
    cyc();
    check("persist_step_addr", bus.rd_addr, 1);
    check("persist_addr1", bus.rd_data, mem_model[1]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
